seq_alu: RTL and testbench

SEQ_ALU -- requirements
Module: seq_alu

---
 rtl/seq_alu.sv | 172 +++++++++++++++++
 tb/tb_seq_alu.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/seq_alu.sv
// Sequential ALU: single-cycle logic/arith ops and a WIDTH-cycle shift-add multiplier.
// Handshake: a transfer occurs on a rising edge where valid && ready; valid holds until then.
module seq_alu #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       alu_ctl,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             overflow,
  output logic             carry_out,
  output logic             illegal,
  output logic [1:0]       dbg_state_o
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_SLT = 4'b0111;
  localparam logic [3:0] OP_NOR = 4'b1100;
  localparam logic [3:0] OP_MUL = 4'b1000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic               zero_q, zero_d;
  logic               ovf_q, ovf_d;
  logic               cout_q, cout_d;
  logic               ill_q, ill_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic [CW-1:0]      cnt_q, cnt_d;

  logic               is_sub;
  logic [WIDTH-1:0]   b_eff;
  logic [WIDTH-1:0]   add_s;
  logic               add_c;
  logic               add_v;
  logic [WIDTH-1:0]   alu_res;
  logic               alu_ovf, alu_cout, alu_ill;
  logic [WIDTH-1:0]   add_w;
  logic [WIDTH:0]     msum;
  logic [2*WIDTH-1:0] acc_nx;

  // One shared adder; SUB and SLT feed it a + ~b + 1.
  always_comb begin
    is_sub         = (alu_ctl == OP_SUB) || (alu_ctl == OP_SLT);
    b_eff          = is_sub ? ~b : b;
    {add_c, add_s} = {1'b0, a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, is_sub};
    add_v          = (a[WIDTH-1] == b_eff[WIDTH-1]) && (add_s[WIDTH-1] != a[WIDTH-1]);
    alu_res        = '0;
    alu_ovf        = 1'b0;
    alu_cout       = 1'b0;
    alu_ill        = 1'b0;
    case (alu_ctl)
      OP_AND: alu_res = a & b;
      OP_OR:  alu_res = a | b;
      OP_NOR: alu_res = ~(a | b);
      OP_ADD, OP_SUB: begin
        alu_res  = add_s;
        alu_ovf  = add_v;
        alu_cout = add_c;
      end
      OP_SLT: alu_res = {{(WIDTH-1){1'b0}}, add_s[WIDTH-1] ^ add_v};
      OP_MUL: alu_res = '0;
      default: alu_ill = 1'b1;
    endcase
  end

  // Multiplier step: acc holds {partial product, remaining multiplier bits}.
  always_comb begin
    add_w  = acc_q[0] ? mcand_q : '0;
    msum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, add_w};
    acc_nx = {msum, acc_q[WIDTH-1:1]};
  end

  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    zero_d   = zero_q;
    ovf_d    = ovf_q;
    cout_d   = cout_q;
    ill_d    = ill_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    cnt_d    = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          if (alu_ctl == OP_MUL) begin
            state_d = ST_MUL;
            acc_d   = {{WIDTH{1'b0}}, b};
            mcand_d = a;
            cnt_d   = '0;
          end else begin
            state_d  = ST_DONE;
            result_d = alu_res;
            zero_d   = (alu_res == '0);
            ovf_d    = alu_ovf;
            cout_d   = alu_cout;
            ill_d    = alu_ill;
          end
        end
      end
      ST_MUL: begin
        acc_d = acc_nx;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH-1)) begin
          state_d  = ST_DONE;
          result_d = acc_nx[WIDTH-1:0];
          zero_d   = (acc_nx[WIDTH-1:0] == '0);
          ovf_d    = |acc_nx[2*WIDTH-1:WIDTH];
          cout_d   = 1'b0;
          ill_d    = 1'b0;
        end
      end
      ST_DONE: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      result_q <= '0;
      zero_q   <= 1'b0;
      ovf_q    <= 1'b0;
      cout_q   <= 1'b0;
      ill_q    <= 1'b0;
      acc_q    <= '0;
      mcand_q  <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      zero_q   <= zero_d;
      ovf_q    <= ovf_d;
      cout_q   <= cout_d;
      ill_q    <= ill_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      cnt_q    <= cnt_d;
    end
  end

  assign in_ready    = (state_q == ST_IDLE);
  assign out_valid   = (state_q == ST_DONE);
  assign result      = result_q;
  assign zero        = zero_q;
  assign overflow    = ovf_q;
  assign carry_out   = cout_q;
  assign illegal     = ill_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_seq_alu.sv
// Directed bench for seq_alu (WIDTH=32): flags, latency, backpressure, reset abort.
module tb_seq_alu;
  localparam int W = 32;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [3:0]   alu_ctl;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic         zero;
  logic         overflow;
  logic         carry_out;
  logic         illegal;
  logic [1:0]   dbg_state;

  int n_cmp = 0;
  int n_bad = 0;

  seq_alu #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .a          (a),
    .b          (b),
    .alu_ctl    (alu_ctl),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .result     (result),
    .zero       (zero),
    .overflow   (overflow),
    .carry_out  (carry_out),
    .illegal    (illegal),
    .dbg_state_o(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // driver: present one op at a negedge, leave after the accepting edge
  task automatic issue(input logic [3:0] ctl, input logic [W-1:0] av, input logic [W-1:0] bv);
    int guard;
    guard = 0;
    while (!in_ready && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    check("issue_ready_timeout", 64'(in_ready), 64'd1);
    alu_ctl  = ctl;
    a        = av;
    b        = bv;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    a        = $urandom;
    b        = $urandom;
    alu_ctl  = 4'($urandom_range(0, 15));
  endtask

  task automatic pop(input string tag);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check({tag, "_pop_valid"}, 64'(out_valid), 64'd0);
    check({tag, "_pop_ready"}, 64'(in_ready), 64'd1);
  endtask

  task automatic check_out(input string tag, input logic [W-1:0] res,
                           input logic z, input logic v, input logic c, input logic il);
    check({tag, "_valid"},   64'(out_valid), 64'd1);
    check({tag, "_result"},  64'(result),    64'(res));
    check({tag, "_zero"},    64'(zero),      64'(z));
    check({tag, "_ovf"},     64'(overflow),  64'(v));
    check({tag, "_cout"},    64'(carry_out), 64'(c));
    check({tag, "_illegal"}, 64'(illegal),   64'(il));
  endtask

  initial begin
    int cyc;
    logic rdy_seen;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a         = '0;
    b         = '0;
    alu_ctl   = '0;
    repeat (2) @(negedge clk);
    check("rst_valid",  64'(out_valid), 64'd0);
    check("rst_result", 64'(result),    64'd0);
    check("rst_flags",  64'({zero, overflow, carry_out, illegal}), 64'd0);
    check("rst_state",  64'(dbg_state), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_in_ready", 64'(in_ready), 64'd1);

    issue(4'b0010, 32'h7FFF_FFFF, 32'd1);
    check_out("add_ovf", 32'h8000_0000, 1'b0, 1'b1, 1'b0, 1'b0);
    pop("add_ovf");

    issue(4'b0010, 32'hFFFF_FFFF, 32'd1);
    check_out("add_carry", 32'h0, 1'b1, 1'b0, 1'b1, 1'b0);
    pop("add_carry");

    issue(4'b0110, 32'd5, 32'd5);
    check_out("sub_eq", 32'h0, 1'b1, 1'b0, 1'b1, 1'b0);
    pop("sub_eq");

    issue(4'b0110, 32'd3, 32'd5);
    check_out("sub_borrow", 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0, 1'b0);
    pop("sub_borrow");

    issue(4'b0111, 32'h8000_0000, 32'd1);
    check_out("slt_ovf", 32'd1, 1'b0, 1'b0, 1'b0, 1'b0);
    pop("slt_ovf");

    issue(4'b0000, 32'hFF00_FF00, 32'h0FF0_0FF0);
    check_out("and", 32'h0F00_0F00, 1'b0, 1'b0, 1'b0, 1'b0);
    pop("and");

    issue(4'b1100, 32'h0, 32'h0);
    check_out("nor", 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0, 1'b0);
    pop("nor");

    // MUL overflowing into the upper half, latency counted in cycles after acceptance
    issue(4'b1000, 32'h0001_0000, 32'h0001_0000);
    cyc = 1;
    rdy_seen = 1'b0;
    while (!out_valid && cyc < 100) begin
      if (in_ready) rdy_seen = 1'b1;
      @(negedge clk);
      cyc++;
    end
    check("mul_latency", 64'(cyc), 64'd33);
    check("mul_busy_ready", 64'(rdy_seen), 64'd0);
    check_out("mul_big", 32'h0, 1'b1, 1'b1, 1'b0, 1'b0);
    pop("mul_big");

    issue(4'b1000, 32'd7, 32'd6);
    repeat (32) @(negedge clk);
    check_out("mul_small", 32'd42, 1'b0, 1'b0, 1'b0, 1'b0);
    pop("mul_small");

    // backpressure: result must hold while out_ready is low
    issue(4'b0001, 32'hF0, 32'h0F);
    for (int i = 0; i < 5; i++) begin
      check("bp_valid",  64'(out_valid), 64'd1);
      check("bp_result", 64'(result),    64'hFF);
      check("bp_ready",  64'(in_ready),  64'd0);
      @(negedge clk);
    end
    // offer a new op in the same cycle as the handshake: must not be taken yet
    out_ready = 1'b1;
    in_valid  = 1'b1;
    alu_ctl   = 4'b0010;
    a         = 32'd2;
    b         = 32'd3;
    @(negedge clk);
    out_ready = 1'b0;
    check("bp_release_valid", 64'(out_valid), 64'd0);
    check("bp_release_ready", 64'(in_ready),  64'd1);
    @(negedge clk);
    in_valid = 1'b0;
    check_out("after_bp_add", 32'd5, 1'b0, 1'b0, 1'b0, 1'b0);
    pop("after_bp_add");

    // reset during MUL cycle 10
    issue(4'b1000, 32'd3, 32'd9);
    repeat (9) @(negedge clk);
    check("mid_mul_state", 64'(dbg_state), 64'd1);
    rst_n = 1'b0;
    #1;
    check("abort_valid",  64'(out_valid), 64'd0);
    check("abort_result", 64'(result),    64'd0);
    check("abort_ready",  64'(in_ready),  64'd1);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("post_rst_ready", 64'(in_ready),  64'd1);
    check("post_rst_valid", 64'(out_valid), 64'd0);
    @(negedge clk);
    issue(4'b0010, 32'd2, 32'd3);
    check_out("post_rst_add", 32'd5, 1'b0, 1'b0, 1'b0, 1'b0);
    pop("post_rst_add");

    issue(4'b1111, 32'h1234_5678, 32'h9ABC_DEF0);
    check_out("illegal", 32'h0, 1'b1, 1'b0, 1'b0, 1'b1);
    pop("illegal");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
